// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder walks the operands LSB first.
// Define SERIAL_ADD_OVF_EN to add the two's-complement ovf output.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_s, fa_co;

  full_adder u_fa (
    .a  (a_q[idx_q]),
    .b  (b_q[idx_q]),
    .ci (c_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state: capture on start, one bit per RUN cycle, single DONE cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[idx_q] = fa_s;
        c_d          = fa_co;
        idx_d        = idx_q + IW'(1);
        if (idx_q == LAST) begin
          // Carry into the MSB is still in c_q here.
          idx_d   = '0;
          cout_d  = fa_co;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = c_q ^ fa_co;
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed + random bench for serial_add_ctrl (WIDTH=8).
// Reference results come from plain integer arithmetic.

module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
    .ovf   (ovf),
`endif
    .cout  (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ref_add(input logic [7:0] x,
                                         input logic [7:0] y,
                                         input logic c);
    int t;
    t = int'(x) + int'(y) + int'(c);
    return t[8:0];
  endfunction

  function automatic logic ref_ovf(input logic [7:0] x,
                                   input logic [7:0] y,
                                   input logic c);
    int s;
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    return (s > 127) || (s < -128);
  endfunction

  task automatic run_one(input logic [7:0] va, input logic [7:0] vb,
                         input logic vc, input string tag);
    logic [8:0] r;
    logic       v;
    int         nb;
    int         g;
    r = ref_add(va, vb, vc);
    v = ref_ovf(va, vb, vc);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy_first"}, busy, 1);
    chk({tag, ".sum_clr"}, sum, 0);
    chk({tag, ".cout_clr"}, cout, 0);
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    nb = 1;
    g = 0;
    while (!done && g < 20) begin
      @(negedge clk);
      if (busy) nb++;
      g++;
    end
    chk({tag, ".busy_cycles"}, nb, W);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".busy_in_done"}, busy, 0);
    chk({tag, ".sum"}, sum, r[7:0]);
    chk({tag, ".cout"}, cout, r[8]);
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, ".ovf"}, ovf, v);
`endif
    @(negedge clk);
    chk({tag, ".done_1cyc"}, done, 0);
    chk({tag, ".sum_hold"}, sum, r[7:0]);
    chk({tag, ".cout_hold"}, cout, r[8]);
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, ".ovf_hold"}, ovf, v);
`endif
  endtask

  initial begin
    logic [8:0] r;
    logic [8:0] rp;
    int nd;
    int g;
    int last;

    // Reset, with start asserted to show reset wins.
    start = 1'b1; a = 8'h12; b = 8'h34;
    repeat (2) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.sum", sum, 0);
    chk("rst.cout", cout, 0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst.ovf", ovf, 0);
`endif
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    run_one(8'h5A, 8'h3C, 1'b0, "v5a3c");
    run_one(8'hFF, 8'h01, 1'b0, "vff01");
    run_one(8'hFF, 8'h00, 1'b1, "vff00c");
    run_one(8'h7F, 8'h01, 1'b0, "v7f01");
    run_one(8'h80, 8'h80, 1'b0, "v8080");
    run_one(8'h10, 8'h20, 1'b0, "v1020");
    run_one(8'h00, 8'h00, 1'b0, "v0000");

    // Second start during RUN is ignored.
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'hF0;
    nd = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 6) start = 1'b0;
      if (done) begin
        nd++;
        chk("ign.sum", sum, 8'h02);
        chk("ign.cout", cout, 0);
      end
      @(negedge clk);
    end
    chk("ign.ndone", nd, 1);

    // Reset in the middle of RUN aborts.
    a = 8'h11; b = 8'h22; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort.busy", busy, 0);
    chk("abort.sum", sum, 0);
    chk("abort.done", done, 0);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort.nodone", nd, 0);
    run_one(8'h03, 8'h04, 1'b0, "v0304");

    // Random operands.
    for (int i = 0; i < 16; i++)
      run_one(W'($urandom), W'($urandom), 1'($urandom), "rnd");

    // Start held high: back-to-back additions.
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    start = 1'b1;
    last = 0;
    rp = '0;
    for (int k = 0; k < 5; k++) begin
      g = 0;
      while (!busy && g < 12) begin
        @(negedge clk);
        g++;
      end
      chk("held.accept", busy, 1);
      chk("held.sum_clr", sum, 0);
      r = ref_add(a, b, cin);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      g = 0;
      while (!done && g < 20) begin
        @(negedge clk);
        g++;
      end
      chk("held.done", done, 1);
      chk("held.sum", sum, r[7:0]);
      chk("held.cout", cout, r[8]);
      if (k > 0) chk("held.period", cyc - last, 10);
      last = cyc;
      rp = r;
      @(negedge clk);
      if (k == 4) start = 1'b0;
      chk("held.sum_hold", sum, rp[7:0]);
      chk("held.cout_hold", cout, rp[8]);
      chk("held.idle", busy, 0);
    end
    repeat (3) @(negedge clk);
    chk("end.busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
